// File: rtl/stream_mux_pkg.sv
// Shared constants and the round-robin search helper for stream_mux_rr.
package stream_mux_pkg;

   localparam logic MODE_RR    = 1'b0;
   localparam logic MODE_FIXED = 1'b1;
   localparam int unsigned MAX_N = 16;

   // Index of the first set bit of valid at or above ptr, wrapping within n channels; 0 if none.
   function automatic int unsigned rr_next(input logic [3:0] ptr, input logic [15:0] valid,
                                           input int unsigned n);
      int unsigned res;
      logic        found;
      logic [4:0]  sum;
      res   = 0;
      found = 1'b0;
      for (int unsigned k = 0; k < MAX_N; k++) begin
         sum = 5'(ptr) + k[4:0];
         if (32'(sum) >= n) sum = sum - 5'(n);
         if (k < n && !found && valid[sum[3:0]]) begin
            res   = 32'(sum);
            found = 1'b1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first valid channel searching upward from ptr with wrap.
module rr_arbiter import stream_mux_pkg::*; #(
   parameter int unsigned N     = 4,
   parameter int unsigned SEL_W = $clog2(N)
) (
   input  logic [N-1:0]     valid,
   input  logic [SEL_W-1:0] ptr,
   output logic             grant_vld,
   output logic [SEL_W-1:0] grant_idx
);

   logic [MAX_N-1:0] valid_ext;

   always_comb begin
      valid_ext        = '0;
      valid_ext[N-1:0] = valid;
      grant_vld        = |valid;
      grant_idx        = SEL_W'(rr_next(4'(ptr), valid_ext, N));
   end

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 stream mux with round-robin or fixed select and a single output register stage.
// Define STREAM_MUX_RR_LAST_EN to add in_last/out_last and hold the grant until end of packet.
module stream_mux_rr import stream_mux_pkg::*; #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned N     = 4,
   parameter int unsigned SEL_W = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               mode,
   input  logic [SEL_W-1:0]   s,
   input  logic [N-1:0]       in_valid,
   input  logic [N*WIDTH-1:0] in_data,
   output logic [N-1:0]       in_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [SEL_W-1:0]   out_sel,
   input  logic               out_ready
`ifdef STREAM_MUX_RR_LAST_EN
   ,
   input  logic [N-1:0]       in_last,
   output logic               out_last
`endif
);

   logic             load_en, accept, advance, lock_hold;
   logic             rr_vld, gnt_vld;
   logic [SEL_W-1:0] rr_idx, gnt_idx, ptr_q, ptr_d;
   logic [WIDTH-1:0] gnt_data, out_data_q;
   logic [SEL_W-1:0] out_sel_q;
   logic             out_valid_q;

   rr_arbiter #(
      .N     (N),
      .SEL_W (SEL_W)
   ) u_arb (
      .valid     (in_valid),
      .ptr       (ptr_q),
      .grant_vld (rr_vld),
      .grant_idx (rr_idx)
   );

`ifdef STREAM_MUX_RR_LAST_EN
   logic lock_q, lock_d, gnt_last, out_last_q;
   assign lock_hold = lock_q;
   assign out_last  = out_last_q;
`else
   assign lock_hold = 1'b0;
`endif

   always_comb begin
      load_en = !out_valid_q || out_ready;
      // While locked the held channel is the one whose beat was last loaded.
      if (lock_hold) begin
         gnt_vld = 1'b1;
         gnt_idx = out_sel_q;
      end else if (mode == MODE_FIXED) begin
         gnt_vld = 32'(s) < N;
         gnt_idx = s;
      end else begin
         gnt_vld = rr_vld;
         gnt_idx = rr_idx;
      end
      in_ready = '0;
      gnt_data = '0;
`ifdef STREAM_MUX_RR_LAST_EN
      gnt_last = 1'b0;
`endif
      for (int unsigned i = 0; i < N; i++) begin
         if (32'(gnt_idx) == i) begin
            in_ready[i] = gnt_vld && load_en && rst_n;
            gnt_data    = in_data[i*WIDTH +: WIDTH];
`ifdef STREAM_MUX_RR_LAST_EN
            gnt_last    = in_last[i];
`endif
         end
      end
      accept = |(in_valid & in_ready);
`ifdef STREAM_MUX_RR_LAST_EN
      advance = accept && gnt_last;
      lock_d  = accept ? !gnt_last : lock_q;
`else
      advance = accept;
`endif
      if (!advance)                   ptr_d = ptr_q;
      else if (32'(gnt_idx) == N - 1) ptr_d = '0;
      else                            ptr_d = gnt_idx + SEL_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
`ifdef STREAM_MUX_RR_LAST_EN
         lock_q      <= 1'b0;
         out_last_q  <= 1'b0;
`endif
      end else begin
         ptr_q <= ptr_d;
         if (load_en) out_valid_q <= accept;
         if (accept) begin
            out_data_q <= gnt_data;
            out_sel_q  <= gnt_idx;
`ifdef STREAM_MUX_RR_LAST_EN
            out_last_q <= gnt_last;
`endif
         end
`ifdef STREAM_MUX_RR_LAST_EN
         lock_q <= lock_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: vector table, hand sequences and a scoreboard model.
`timescale 1ns/1ps
module tb_stream_mux_rr;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned N     = 4;
   localparam int unsigned SEL_W = 2;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               mode = 1'b0;
   logic [SEL_W-1:0]   s = '0;
   logic [N-1:0]       in_valid = '0;
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_ready;
   logic               out_valid;
   logic [WIDTH-1:0]   out_data;
   logic [SEL_W-1:0]   out_sel;
   logic               out_ready = 1'b0;
`ifdef STREAM_MUX_RR_LAST_EN
   logic [N-1:0]       in_last = '0;
   logic               out_last;
`endif

   stream_mux_rr #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .s         (s),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
`ifdef STREAM_MUX_RR_LAST_EN
      ,
      .in_last   (in_last),
      .out_last  (out_last)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [WIDTH-1:0] data;
      logic [SEL_W-1:0] sel;
      logic             last;
   } beat_t;

   beat_t sb[$];
   logic  m_ov = 1'b0;
   logic  m_lock = 1'b0;
   int    m_lock_ch = 0;
   int    m_ptr = 0;
   logic  m_load, m_gv, m_acc, m_last;
   int    m_g;
   logic [N-1:0] m_er;
   beat_t b;

   // Reference model evaluated mid-cycle, predicting the next rising edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         m_ov = 1'b0; m_ptr = 0; m_lock = 1'b0;
         check("rst_in_ready", in_ready, 0);
      end else begin
         m_load = !m_ov || out_ready;
         m_gv = 1'b0; m_g = 0;
         if (m_lock) begin
            m_gv = 1'b1; m_g = m_lock_ch;
         end else if (mode) begin
            m_gv = (s < N); m_g = int'(s);
         end else begin
            for (int k = 0; k < N; k++)
               if (!m_gv && in_valid[(m_ptr + k) % N]) begin
                  m_gv = 1'b1; m_g = (m_ptr + k) % N;
               end
         end
         m_er = (m_gv && m_load) ? N'(1 << m_g) : '0;
         check("sb_in_ready", in_ready, m_er);
         check("sb_out_valid", out_valid, m_ov);
         if (m_ov) begin
            if (sb.size() == 0) begin
               bad++; total++;
               $display("FAIL sb_empty: got empty queue expected a beat");
            end else begin
               check("sb_out_data", out_data, sb[0].data);
               check("sb_out_sel", out_sel, sb[0].sel);
`ifdef STREAM_MUX_RR_LAST_EN
               check("sb_out_last", out_last, sb[0].last);
`endif
            end
         end
         if (m_ov && out_ready && sb.size() > 0) void'(sb.pop_front());
         m_acc = m_gv && m_load && in_valid[m_g];
         if (m_acc) begin
            m_last = 1'b1;
`ifdef STREAM_MUX_RR_LAST_EN
            m_last = in_last[m_g];
`endif
            b.data = in_data[m_g*WIDTH +: WIDTH];
            b.sel  = SEL_W'(m_g);
            b.last = m_last;
            sb.push_back(b);
            if (m_last) begin
               m_lock = 1'b0;
               m_ptr  = (m_g + 1) % N;
            end else begin
               m_lock = 1'b1;
               m_lock_ch = m_g;
            end
         end
         m_ov = m_acc || (m_ov && !out_ready);
      end
   end

   typedef struct {
      logic             md;
      logic [SEL_W-1:0] sv;
      logic [N-1:0]     iv;
      logic             ordy;
      logic [N-1:0]     lst;
      logic [N-1:0]     exp_ready;
      logic             exp_ov;
      logic             chk_sel;
      logic [SEL_W-1:0] exp_sel;
   } vec_t;

   function automatic vec_t mk(input logic md, input logic [SEL_W-1:0] sv, input logic [N-1:0] iv,
                               input logic ordy, input logic [N-1:0] lst, input logic [N-1:0] er,
                               input logic eov, input logic cs, input logic [SEL_W-1:0] es);
      vec_t v;
      v.md = md; v.sv = sv; v.iv = iv; v.ordy = ordy; v.lst = lst;
      v.exp_ready = er; v.exp_ov = eov; v.chk_sel = cs; v.exp_sel = es;
      return v;
   endfunction

   // Drive one vector, check in_ready mid-cycle and the registered outputs after the edge.
   task automatic apply(input vec_t v, input string tag);
      mode = v.md; s = v.sv; in_valid = v.iv; out_ready = v.ordy;
`ifdef STREAM_MUX_RR_LAST_EN
      in_last = v.lst;
`endif
      @(negedge clk);
      check({tag, "_ready"}, in_ready, v.exp_ready);
      @(posedge clk); #1;
      check({tag, "_out_valid"}, out_valid, v.exp_ov);
      if (v.chk_sel) check({tag, "_out_sel"}, out_sel, v.exp_sel);
   endtask

   vec_t tbl[17];
   vec_t hs[4];

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      in_data = {32'h44443333, 32'hDEADBEEF, 32'h22221111, 32'h11110000};
      // round-robin, all valid, starting from ptr 0
      for (int i = 0; i < 8; i++)
         tbl[i] = mk(1'b0, 2'd0, 4'hF, 1'b1, 4'hF, N'(1 << (i % 4)), 1'b1, 1'b1, SEL_W'(i % 4));
      tbl[8]  = mk(1'b0, 2'd0, 4'b0000, 1'b1, 4'hF, 4'b0000, 1'b0, 1'b0, 2'd0);
      tbl[9]  = mk(1'b0, 2'd0, 4'b0100, 1'b1, 4'hF, 4'b0100, 1'b1, 1'b1, 2'd2);
      tbl[10] = mk(1'b0, 2'd0, 4'b0001, 1'b1, 4'hF, 4'b0001, 1'b1, 1'b1, 2'd0);
      tbl[11] = mk(1'b0, 2'd0, 4'b1111, 1'b1, 4'hF, 4'b0010, 1'b1, 1'b1, 2'd1);
      tbl[12] = mk(1'b1, 2'd2, 4'b1111, 1'b1, 4'hF, 4'b0100, 1'b1, 1'b1, 2'd2);
      tbl[13] = mk(1'b1, 2'd2, 4'b1111, 1'b1, 4'hF, 4'b0100, 1'b1, 1'b1, 2'd2);
      tbl[14] = mk(1'b1, 2'd2, 4'b1011, 1'b1, 4'hF, 4'b0100, 1'b0, 1'b0, 2'd0);
      tbl[15] = mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'hF, 4'b0001, 1'b1, 1'b1, 2'd0);
      tbl[16] = mk(1'b0, 2'd0, 4'b0000, 1'b1, 4'hF, 4'b0000, 1'b0, 1'b0, 2'd0);

      #1;
      check("reset_out_valid", out_valid, 0);
      check("reset_out_data", out_data, 0);
      check("reset_out_sel", out_sel, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 17; i++) begin
         apply(tbl[i], $sformatf("v%0d", i));
         if (i == 10) check("wrap_ptr", dut.ptr_q, 1);
         if (i == 12) check("fixed_data", out_data, 32'hDEADBEEF);
      end

      // stall: load channel 3 (ptr 1 -> 0), then hold with out_ready low
      apply(mk(1'b0, 2'd0, 4'b1000, 1'b1, 4'hF, 4'b1000, 1'b1, 1'b1, 2'd3), "stall_load");
      for (int i = 0; i < 5; i++) begin
         apply(mk(1'b0, 2'd0, 4'b1010, 1'b0, 4'hF, 4'b0000, 1'b1, 1'b1, 2'd3), "stall_hold");
         check("stall_data", out_data, 32'h44443333);
         check("stall_ptr", dut.ptr_q, 0);
      end
      apply(mk(1'b0, 2'd0, 4'b1010, 1'b1, 4'hF, 4'b0010, 1'b1, 1'b1, 2'd1), "stall_rel1");
      apply(mk(1'b0, 2'd0, 4'b1010, 1'b1, 4'hF, 4'b1000, 1'b1, 1'b1, 2'd3), "stall_rel3");
      apply(mk(1'b0, 2'd0, 4'b0000, 1'b1, 4'hF, 4'b0000, 1'b0, 1'b0, 2'd0), "drain");

      // reset mid-stall with a beat held and ptr at 1
      apply(mk(1'b0, 2'd0, 4'b0001, 1'b1, 4'hF, 4'b0001, 1'b1, 1'b1, 2'd0), "pre_rst");
      apply(mk(1'b0, 2'd0, 4'b0000, 1'b0, 4'hF, 4'b0000, 1'b1, 1'b1, 2'd0), "rst_stall");
      @(negedge clk);
      #2 rst_n = 1'b0;
      in_valid = 4'hF;
      #1;
      check("async_rst_out_valid", out_valid, 0);
      check("async_rst_out_data", out_data, 0);
      check("async_rst_out_sel", out_sel, 0);
      check("async_rst_in_ready", in_ready, 0);
      check("async_rst_ptr", dut.ptr_q, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      apply(mk(1'b0, 2'd0, 4'hF, 1'b1, 4'hF, 4'b0001, 1'b1, 1'b1, 2'd0), "post_rst");

`ifdef STREAM_MUX_RR_LAST_EN
      // ch1 packet of 3 beats; mode/s change while locked waits for the last beat
      hs[0] = mk(1'b0, 2'd0, 4'b0110, 1'b1, 4'b0000, 4'b0010, 1'b1, 1'b1, 2'd1);
      hs[1] = mk(1'b1, 2'd2, 4'b0110, 1'b1, 4'b0000, 4'b0010, 1'b1, 1'b1, 2'd1);
      hs[2] = mk(1'b1, 2'd2, 4'b0110, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b1, 2'd1);
      hs[3] = mk(1'b1, 2'd2, 4'b0110, 1'b1, 4'b0100, 4'b0100, 1'b1, 1'b1, 2'd2);
      for (int i = 0; i < 4; i++) apply(hs[i], $sformatf("lock%0d", i));
`endif

      apply(mk(1'b0, 2'd0, 4'b0000, 1'b1, 4'hF, 4'b0000, 1'b0, 1'b0, 2'd0), "final_drain");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
